// File: rtl/duart_rx_channel.sv
// 8N1 serial receiver channel: 2-flop synchroniser, mid-bit sampling FSM, 3-entry FIFO of {byte, framing error}.
// Byte visible on rx_rdy one clk after the stop-bit sample; host pops via pop, and a push into a full FIFO without pop is dropped (sticky overrun).
module duart_rx_channel #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_enable,
  input  logic       pop,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_ful,
  output logic       framing_err,
  output logic       overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_sync;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic          push;
  logic [8:0]    push_dat;

  logic [8:0]    mem [0:2];
  logic [1:0]    rd_ptr;
  logic [1:0]    wr_ptr;
  logic [1:0]    count;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [8:0]    head;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (!rx_enable) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= ST_START;
        end
        // Re-check the line at mid start bit to reject glitches.
        ST_START: begin
          if (timer == HALF_BIT) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DATA: begin
          if (timer == BIT_LAST) begin
            shreg[bit_idx] <= rx_sync;
            timer          <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= rx_sync ? ST_IDLE : ST_BREAK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        // Wait out a held-low line so a break does not re-trigger reception.
        ST_BREAK: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push     = rx_enable && (state == ST_STOP) && (timer == BIT_LAST);
  assign push_dat = {shreg, ~rx_sync};

  assign fifo_full = (count == 2'd3);
  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && (!fifo_full || do_pop);
  assign drop      = push && fifo_full && !do_pop;

  // When full, wr_ptr equals rd_ptr, so a push+pop overwrites the slot being popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign rx_rdy      = (count != 2'd0);
  assign rx_ful      = fifo_full;
  assign rx_data     = rx_rdy ? head[8:1] : 8'h00;
  assign framing_err = rx_rdy & head[0];

endmodule

// File: tb/tb_duart_rx_channel.sv
// Directed bench for duart_rx_channel at 434 clk/bit; frames are driven bit-by-bit on the falling clock edge.
module tb_duart_rx_channel;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_enable;
  logic       pop;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ful;
  logic       framing_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int first_rdy_c;

  duart_rx_channel #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_enable(rx_enable), .pop(pop),
    .clr_err(clr_err), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ful(rx_ful),
    .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Drives one frame from the current negedge. strobe_c pulses pop or clr_err at that
  // cycle; dis_c drops rx_enable; rst_c aborts the frame with a reset pulse.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int strobe_c,
                            input logic strobe_is_pop, input int dis_c, input int rst_c);
    first_rdy_c = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (rx_rdy && first_rdy_c < 0) first_rdy_c = c;
      if (c == rst_c) begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (c < CPB)          rx = 1'b0;
      else if (c < 9 * CPB) rx = b[3'(c / CPB - 1)];
      else                  rx = stop;
      pop     = strobe_is_pop && (c == strobe_c);
      clr_err = !strobe_is_pop && (c == strobe_c);
      if (c == dis_c) rx_enable = 1'b0;
      @(negedge clk);
    end
    pop     = 1'b0;
    clr_err = 1'b0;
    if (!rx_enable) begin
      repeat (4) @(negedge clk);
      rx_enable = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_once();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx_enable = 1'b1; pop = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rx_rdy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (rx_ful !== 1'b0) begin n_fail++; $display("FAIL reset_ful: got %b want 0", rx_ful); end
    n_checks++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", framing_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, 1'b1, -1, -1);
    // 2 sync flops + 1 IDLE clk + 217 start + 9 x 434 bit periods -> push on edge k+4126
    n_checks++; if (first_rdy_c != 4126) begin n_fail++; $display("FAIL single_latency: got %0d want 4126", first_rdy_c); end
    n_checks++; if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b want 1", rx_rdy); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_checks++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL single_fe: got %b want 0", framing_err); end
    n_checks++; if (rx_ful !== 1'b0) begin n_fail++; $display("FAIL single_ful: got %b want 0", rx_ful); end
    pop_once();
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL single_pop_rdy: got %b want 0", rx_rdy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL single_pop_data: got %h want 00", rx_data); end
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b want 0", rx_rdy); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    send_frame(8'h01, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h02, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h03, 1'b1, -1, 1'b1, -1, -1);
    n_checks++; if (rx_ful !== 1'b1) begin n_fail++; $display("FAIL ovr_ful3: got %b want 1", rx_ful); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b want 0", overrun); end
    // clr_err coincides with the dropped push: set must win
    send_frame(8'h04, 1'b1, 4125, 1'b0, -1, -1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_checks++; if (rx_ful !== 1'b1) begin n_fail++; $display("FAIL ovr_ful: got %b want 1", rx_ful); end
    for (int i = 1; i <= 3; i++) begin
      exp = 8'(i);
      n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL ovr_order%0d: got %h want %h", i, rx_data, exp); end
      pop_once();
    end
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b want 0", rx_rdy); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    pop_once();
    pop_once();
    n_checks++; if (rx_rdy !== 1'b0 || rx_ful !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got rdy=%b ful=%b want 0 0", rx_rdy, rx_ful); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_break();
    send_frame(8'h55, 1'b0, -1, 1'b1, -1, -1);
    n_checks++; if (rx_data !== 8'h55 || framing_err !== 1'b1) begin n_fail++; $display("FAIL brk_first: got %h fe=%b want 55 fe=1", rx_data, framing_err); end
    repeat (5000) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h66, 1'b1, -1, 1'b1, -1, -1);
    n_checks++; if (rx_ful !== 1'b0) begin n_fail++; $display("FAIL brk_count: got ful=%b want 0", rx_ful); end
    n_checks++; if (rx_data !== 8'h55 || framing_err !== 1'b1) begin n_fail++; $display("FAIL brk_head: got %h fe=%b want 55 fe=1", rx_data, framing_err); end
    pop_once();
    n_checks++; if (rx_data !== 8'h66 || framing_err !== 1'b0) begin n_fail++; $display("FAIL brk_second: got %h fe=%b want 66 fe=0", rx_data, framing_err); end
    pop_once();
    n_checks++; if (rx_rdy !== 1'b0 || framing_err !== 1'b0) begin n_fail++; $display("FAIL brk_empty: got rdy=%b fe=%b want 0 0", rx_rdy, framing_err); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    send_frame(8'h01, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h02, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h03, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h04, 1'b1, 4125, 1'b1, -1, -1);
    n_checks++; if (rx_ful !== 1'b1) begin n_fail++; $display("FAIL fullpop_ful: got %b want 1", rx_ful); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovr: got %b want 0", overrun); end
    for (int i = 2; i <= 4; i++) begin
      exp = 8'(i);
      n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL fullpop_order%0d: got %h want %h", i, rx_data, exp); end
      pop_once();
    end
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", rx_rdy); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hE7, 1'b1, -1, 1'b1, -1, 5 * CPB + 100);
    repeat (600) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 0", rx_rdy); end
    send_frame(8'h3C, 1'b1, -1, 1'b1, -1, -1);
    n_checks++; if (rx_data !== 8'h3C || rx_ful !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %h ful=%b want 3c ful=0", rx_data, rx_ful); end
    pop_once();
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_only: got %b want 0", rx_rdy); end
  endtask

  task automatic test_enable();
    send_frame(8'h81, 1'b1, -1, 1'b1, -1, -1);
    send_frame(8'h99, 1'b1, -1, 1'b1, 3 * CPB + 50, -1);
    n_checks++; if (rx_data !== 8'h81 || rx_rdy !== 1'b1) begin n_fail++; $display("FAIL en_head: got %h rdy=%b want 81 rdy=1", rx_data, rx_rdy); end
    n_checks++; if (rx_ful !== 1'b0 || framing_err !== 1'b0) begin n_fail++; $display("FAIL en_flags: got ful=%b fe=%b want 0 0", rx_ful, framing_err); end
    pop_once();
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL en_nopush: got %b want 0", rx_rdy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_overrun();
    test_break();
    test_full_pop();
    test_reset_midframe();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
